// File: rtl/arith_pkg.sv
// Shared arithmetic-library definitions: the serial FSM state encoding and a
// helper that sizes bit counters.
package arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // A WIDTH=1 unit still needs a one-bit counter, hence the floor of 1.
  function automatic int cntWidth(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand/result bus of the bit-serial subtractor.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow
  );

endinterface

// File: rtl/full_subtractor.sv
// One-bit full subtractor (a - b - bin) built from two half subtractors and
// an OR gate combining their borrows.
module full_subtractor (
  input  logic i_a,
  input  logic i_b,
  input  logic i_bin,
  output logic o_d,
  output logic o_bout
);

  logic w_d1;
  logic w_b1;
  logic w_b2;

  half_subtractor u_hs1 (
    .i_x    (i_a),
    .i_y    (i_b),
    .o_d    (w_d1),
    .o_bout (w_b1)
  );

  half_subtractor u_hs2 (
    .i_x    (w_d1),
    .i_y    (i_bin),
    .o_d    (o_d),
    .o_bout (w_b2)
  );

  assign o_bout = w_b1 | w_b2;

endmodule

// File: rtl/half_subtractor.sv
// One-bit half subtractor: i_x - i_y with a borrow-out.
module half_subtractor (
  input  logic i_x,
  input  logic i_y,
  output logic o_d,
  output logic o_bout
);

  assign o_d    = i_x ^ i_y;
  assign o_bout = ~i_x & i_y;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: one full-subtractor cell processes one bit
// per clock; diff/borrow update only when an operation completes.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_subtractor_if.slave bus
);

  localparam int CNT_W = cntWidth(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_stateNext;
  logic             w_load;
  logic             w_shift;
  logic             w_last;

  logic [WIDTH-1:0] r_shA;
  logic [WIDTH-1:0] r_shB;
  logic [WIDTH-1:0] r_res;
  logic             r_bin;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;

  logic             w_d;
  logic             w_bout;
  logic [WIDTH-1:0] w_resNext;

  full_subtractor u_fsub (
    .i_a    (r_shA[0]),
    .i_b    (r_shB[0]),
    .i_bin  (r_bin),
    .o_d    (w_d),
    .o_bout (w_bout)
  );

  // New bit enters at the MSB; the whole vector shifts so WIDTH=1 needs no special case.
  assign w_resNext = WIDTH'({w_d, r_res} >> 1);
  assign w_last    = (r_count == LAST_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    bus.busy    = 1'b0;
    bus.done    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_load      = 1'b1;
          w_stateNext = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        bus.busy = 1'b1;
        w_shift  = 1'b1;
        if (w_last) begin
          w_stateNext = ST_DONE;
        end
      end
      ST_DONE: begin
        bus.done = 1'b1;
        if (bus.start) begin
          w_load      = 1'b1;
          w_stateNext = ST_SHIFT;
        end else begin
          w_stateNext = ST_IDLE;
        end
      end
      default: begin
        w_stateNext = ST_IDLE;
      end
    endcase
  end

  // Result registers are written only on the final shift edge, so they never show partial sums.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shA    <= '0;
      r_shB    <= '0;
      r_res    <= '0;
      r_bin    <= 1'b0;
      r_count  <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
    end else if (w_load) begin
      r_shA   <= bus.a;
      r_shB   <= bus.b;
      r_res   <= '0;
      r_bin   <= 1'b0;
      r_count <= '0;
    end else if (w_shift) begin
      r_shA   <= r_shA >> 1;
      r_shB   <= r_shB >> 1;
      r_res   <= w_resNext;
      r_bin   <= w_bout;
      r_count <= r_count + CNT_W'(1);
      if (w_last) begin
        r_diff   <= w_resNext;
        r_borrow <= w_bout;
      end
    end
  end

  assign bus.diff   = r_diff;
  assign bus.borrow = r_borrow;

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial, LSB-first subtractor. Computes diff = a - b with a borrow-out, one bit per clock, through a single full-subtractor cell.
- It is the subtraction counterpart to the combinational adder cells in the arithmetic library.
- Sits as a low-area arithmetic unit with a start/done handshake, usable from a controller FSM or a testbench.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 1..32).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle request; samples a and b when accepted
- a  input  WIDTH  minuend, sampled on the accepting edge only
- b  input  WIDTH  subtrahend, sampled on the accepting edge only
- busy  output  1  high while an operation is in progress (SHIFT state)
- done  output  1  one-cycle pulse; diff and borrow are valid from this cycle
- diff  output  WIDTH  (a - b) mod 2^WIDTH, held until the next completion
- borrow  output  1  1 when a < b (unsigned), held with diff

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, busy=0, done=0, diff=0, borrow=0. Internal shift registers, borrow flop and bit counter are also cleared.
- FSM states: IDLE, SHIFT, DONE.
- IDLE -> SHIFT when start=1. On that edge:
  - load a into sh_a and b into sh_b;
  - clear the result shift register and borrow flop;
  - set the bit counter to 0.
- SHIFT, each edge:
  - d = sh_a[0] ^ sh_b[0] ^ bin
  - bout = (~sh_a[0] & sh_b[0]) | (~(sh_a[0] ^ sh_b[0]) & bin)
  - d shifts into the result MSB (result shifts right);
  - sh_a and sh_b shift right;
  - the borrow flop takes bout;
  - the counter increments.
- SHIFT -> DONE on the edge where the counter reaches WIDTH-1, i.e. after exactly WIDTH shift edges. On that same edge, diff takes the completed result and borrow takes the final bout.
- DONE: done=1 for exactly one cycle.
  - If start=1 in DONE, the block accepts it exactly as in IDLE (back-to-back operation) and goes to SHIFT.
  - Otherwise it goes to IDLE.
- Latency: start accepted at edge k; done is high during the cycle after edge k+WIDTH; diff and borrow change only at edge k+WIDTH.
- Throughput: one result per WIDTH+1 cycles.
- start while busy=1 is ignored. The in-flight operation and its operands are unaffected. The bench must not expect queuing.
- a and b are don't-care except on the accepting edge.
- diff and borrow are stable in IDLE, SHIFT and DONE; they never show partial results.
- busy=1 only in SHIFT; done=1 only in DONE; never both high.
- rst_n asserted mid-SHIFT aborts the operation. All outputs go to reset values immediately and no done pulse follows.
- After rst_n deasserts, the first edge can accept start.
- WIDTH=1: one SHIFT edge. Results are a^b and borrow = ~a & b (half-subtractor truth table).

Decomposition:
- Shared package arith_pkg:
  - state encoding constants ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2;
  - helper localparam CNT_W = clog2(WIDTH), minimum 1.
- Sub-module full_subtractor (combinational, inputs a, b, bin; outputs d, bout), built from two half_subtractor instances plus an OR gate. serial_subtractor instantiates full_subtractor once.
- FSM, counter and shift registers live in the top module.

Test Plan:
- WIDTH=1, exhaustive: (a,b) = 0/0, 0/1, 1/0, 1/1 -> (diff,borrow) = 0/0, 1/1, 1/0, 0/0. done arrives 2 cycles after start.
- WIDTH=8, a=8'd200, b=8'd55 -> diff=8'd145, borrow=0. done pulses exactly 9 cycles after the start edge. busy high for 8 cycles.
- WIDTH=8, a=8'd5, b=8'd10 -> diff=8'd251, borrow=1. Also 8'h00-8'h01 -> 8'hFF, borrow=1; 8'hA5-8'hA5 -> 0, borrow=0.
- Back-to-back: start held high continuously with new operands each acceptance -> results every 9 cycles. start pulses during SHIFT ignored; operands changed mid-SHIFT do not alter the result.
- rst_n dropped at the 4th SHIFT cycle of 8'd100-8'd1 -> busy, done, diff and borrow go to 0 asynchronously with no done pulse. A fresh start of 8'd100-8'd1 then gives 8'd99, borrow=0.
- Hold check: after a completion, idle for 20 cycles -> diff and borrow unchanged and done stays 0.
